// File: rtl/dm_resp.sv
// Word-addressed data-memory responder with valid/ready request and response channels and WAIT wait states.
// Optional DM_BYTE_LANE_EN: stores honour req_be; otherwise every non-error store writes the full word.
module dm_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LAST = 4'((WAIT > 0) ? WAIT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic        ld_ok_q, ld_ok_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic              ex_we;
    logic [31:0]       ex_addr;
    logic [31:0]       ex_wdata;
    logic [3:0]        ex_be;
    logic              ex_err;
    logic [ADDR_W-1:0] ex_idx;
    logic              exec;
    logic              mem_en;
    logic [3:0]        lane_we;
    logic [31:0]       rd_word;

    // With zero wait states the access executes on the accept edge, straight from the request port.
    always_comb begin
        if (state_q == S_IDLE) begin
            ex_we    = req_we;
            ex_addr  = req_addr;
            ex_wdata = req_wdata;
            ex_be    = req_be;
        end else begin
            ex_we    = we_q;
            ex_addr  = addr_q;
            ex_wdata = wdata_q;
            ex_be    = be_q;
        end
        ex_idx = ex_addr[ADDR_W+1:2];
        ex_err = (ex_addr[1:0] != 2'b00) || ((ex_addr >> (ADDR_W + 2)) != 32'd0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        ld_ok_d = ld_ok_q;
        exec    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'd0;
                    if (WAIT == 0) begin
                        exec    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    exec    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (exec) begin
            err_d   = ex_err;
            ld_ok_d = !ex_we && !ex_err;
        end
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            err_q       <= 1'b0;
            ld_ok_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            err_q       <= err_d;
            ld_ok_q     <= ld_ok_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Memory is not reset, so a reset edge must not let a zero-wait accept slip a write through.
    assign mem_en = exec && !reset;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] mem_rd;
`ifdef DM_BYTE_LANE_EN
            assign lane_we[gi] = mem_en && ex_we && !ex_err && ex_be[gi];
`else
            assign lane_we[gi] = mem_en && ex_we && !ex_err;
`endif
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[ex_idx] <= ex_wdata[8*gi +: 8];
                end
                if (mem_en) begin
                    mem_rd <= mem[ex_idx];
                end
            end
            assign rd_word[8*gi +: 8] = mem_rd;
        end
    endgenerate

`ifndef DM_BYTE_LANE_EN
    logic unused_be;
    assign unused_be = ^ex_be;
`endif

    // The read register is only meaningful after an error-free load; stores, errors and reset show zero.
    assign rsp_rdata = ld_ok_q ? rd_word : 32'd0;
    assign rsp_err   = err_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: one WAIT=2 instance for the main scenarios and one WAIT=0 instance for streaming.
module tb_dm_resp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_be;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] exp_lane;
    logic [31:0] held;

    logic        zs_we    [4];
    logic [31:0] zs_addr  [4];
    logic [31:0] zs_wdata [4];
    logic [31:0] zs_exp   [4];

    dm_resp #(.ADDR_W(10), .WAIT(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dm_resp #(.ADDR_W(10), .WAIT(0)) u_dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One full transaction on the WAIT=2 instance; returns just after the response handshake edge.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int cyc);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        cyc = 1;
        while (!rsp_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        $display("txn we=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d",
                 we, addr, wdata, be, rdata, err, cyc);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_req_be = 4'hF;
`ifdef DM_BYTE_LANE_EN
        exp_lane = 32'h12BB_56DD;
`else
        exp_lane = 32'hAABB_CCDD;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        // write then read
        txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, rd, er, lat);
        check("st_lat", 32'(lat), 32'd3);
        check("st_err", 32'(er), 32'd0);
        check("st_rdata", rd, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'hF, rd, er, lat);
        check("ld_lat", 32'(lat), 32'd3);
        check("ld_rdata", rd, 32'h1234_5678);
        check("ld_err", 32'(er), 32'd0);

        // partial store
        txn(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
        check("be_st_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
        check("be_ld_rdata", rd, exp_lane);

        // errors
        txn(1'b0, 32'h12, 32'd0, 4'hF, rd, er, lat);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'd0);
        txn(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        txn(1'b0, 32'h0, 32'd0, 4'hF, rd, er, lat);
        check("oor_mem_kept", rd, 32'h0BAD_F00D);
        check("oor_after_err", 32'(er), 32'd0);

        // backpressure, with stray request activity while busy
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'h5555_5555;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd3);
        held = rsp_rdata;
        check("bp_rdata", held, exp_lane);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_hold%0d", i), rsp_rdata, exp_lane);
            check($sformatf("bp_req_ready%0d", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0; req_we = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_req_ready_after", 32'(req_ready), 32'd1);
        check("bp_valid_after", 32'(rsp_valid), 32'd0);
        check("bp_rdata_kept", rsp_rdata, exp_lane);
        $display("txn backpressure load addr=00000010 rdata=%h", held);
        txn(1'b0, 32'h10, 32'd0, 4'hF, rd, er, lat);
        check("bp_ignored_store", rd, exp_lane);

        // reset during WAIT
        txn(1'b1, 32'h20, 32'h1111_2222, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rstw_valid_later", 32'(rsp_valid), 32'd0);
        check("rstw_rdata", rsp_rdata, 32'd0);
        $display("txn reset-aborted store addr=00000020 wdata=deadbeef");
        txn(1'b0, 32'h20, 32'd0, 4'hF, rd, er, lat);
        check("rstw_mem_kept", rd, 32'h1111_2222);

        // zero-wait streaming on the second instance
        zs_we[0] = 1'b1; zs_addr[0] = 32'h0; zs_wdata[0] = 32'hCAFE_0001; zs_exp[0] = 32'd0;
        zs_we[1] = 1'b1; zs_addr[1] = 32'h4; zs_wdata[1] = 32'hCAFE_0002; zs_exp[1] = 32'd0;
        zs_we[2] = 1'b0; zs_addr[2] = 32'h0; zs_wdata[2] = 32'd0;         zs_exp[2] = 32'hCAFE_0001;
        zs_we[3] = 1'b0; zs_addr[3] = 32'h4; zs_wdata[3] = 32'd0;         zs_exp[3] = 32'hCAFE_0002;
        @(negedge clk);
        check("z_idle_ready", 32'(z_req_ready), 32'd1);
        z_req_valid = 1'b1;
        z_req_we = zs_we[0]; z_req_addr = zs_addr[0]; z_req_wdata = zs_wdata[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("z_valid%0d", i), 32'(z_rsp_valid), 32'd1);
            check($sformatf("z_busy%0d", i), 32'(z_req_ready), 32'd0);
            check($sformatf("z_rdata%0d", i), z_rsp_rdata, zs_exp[i]);
            check($sformatf("z_err%0d", i), 32'(z_rsp_err), 32'd0);
            $display("txn z we=%0b addr=%h wdata=%h -> rdata=%h", zs_we[i], zs_addr[i], zs_wdata[i], z_rsp_rdata);
            if (i < 3) begin
                z_req_we = zs_we[i+1]; z_req_addr = zs_addr[i+1]; z_req_wdata = zs_wdata[i+1];
            end else begin
                z_req_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("z_gap_valid%0d", i), 32'(z_rsp_valid), 32'd0);
            check($sformatf("z_gap_ready%0d", i), 32'(z_req_ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_resp.md
# dm_resp

Word-addressed data-memory responder that answers load/store requests from the MIPS core's memory port. It sits opposite the core's data-access initiator and stores 4 KiB by default. It accepts one request at a time through a valid/ready handshake, inserts a parameterised number of wait states, and returns read data or a write acknowledge through a second valid/ready handshake. Misaligned and out-of-range accesses complete with an error flag.

## Interface
- ADDR_W, 10, word-address width; depth = 2^ADDR_W words (default 1024 words = 4 KiB)
- WAIT, 2, wait-state cycles between request acceptance and response (0..15)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator takes the response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- req_ready = (state == IDLE). rsp_valid = (state == RESP).
- **IDLE:** if req_valid && req_ready, latch we/addr/wdata/be and clear the wait counter.
  - Next state is WAIT if WAIT > 0, otherwise RESP.
- **WAIT:** the counter increments each cycle. When counter == WAIT-1, the FSM executes the access and goes to RESP.
- **Execute** happens on the edge that enters RESP.
  - Error check: err = (addr[1:0] != 0) || (addr[31:ADDR_W+2] != 0).
  - On error: no memory write, rdata = 0, err = 1.
  - Store, no error: write mem[addr[ADDR_W+1:2]] lane by lane under be. rdata = 0.
  - Load, no error: rdata = mem[addr[ADDR_W+1:2]]. be is ignored.
- **RESP:** rsp_rdata and rsp_err are held stable. When rsp_ready is 1, the FSM goes to IDLE. The held values stay on the outputs until the next execute.
- Memory contents are not initialised and are unaffected by reset.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; state = IDLE; counter = 0. The latched request is cleared.
- No handshake is recognised while reset is high.
- Latency: the accept edge is cycle 0. rsp_valid is high from cycle WAIT+1 onward.
- Throughput: at best one request per WAIT+2 cycles. req_ready is low from the accept edge until the edge after the response handshake.
- Backpressure: rsp_valid and the response data are held for as long as rsp_ready = 0. Holding is unbounded.
- A store becomes visible to the next load. It is written before rsp_valid rises.
- Reset during WAIT or RESP:
  - Return to IDLE immediately; drop the request and the response.
  - If the execute edge has not yet occurred, memory is unchanged.
- Changes on req_* while not in IDLE are ignored.

## Configuration
- DM_BYTE_LANE_EN defined: stores honour req_be, updating only enabled lanes. A store with be = 4'b0000 completes without modifying memory.
- DM_BYTE_LANE_EN undefined: req_be is ignored and every non-error store writes all 32 bits.

## Test plan
- **Write then read (WAIT=2):**
  - Store 0x12345678 to 0x0000_0010 with be = 4'hF. Expect rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
  - Load 0x10. Expect rsp_rdata = 0x12345678.
- **Byte lanes (DM_BYTE_LANE_EN defined):**
  - Over 0x12345678 at 0x10, store 0xAABBCCDD with be = 4'b0101. A load returns 0x12BB56DD.
  - With DM_BYTE_LANE_EN undefined, the load returns 0xAABBCCDD.
- **Errors:**
  - Load from 0x0000_0012 gives rsp_err = 1, rsp_rdata = 0.
  - Store 0xFFFFFFFF to 0x0000_1000 gives rsp_err = 1, and a load from 0x0 is unchanged.
- **Backpressure:** load with rsp_ready held 0 for 5 cycles. rsp_valid and rsp_rdata stay stable and req_ready stays 0. The response completes on the first rsp_ready = 1 cycle, and req_ready = 1 on the following cycle.
- **Reset mid-WAIT:** store 0xDEADBEEF to 0x20 and pulse reset in cycle 1 after accept. Expect rsp_valid = 0, req_ready = 1, and a load from 0x20 returns the prior contents.
- **Zero wait (WAIT=0):** back-to-back loads with rsp_ready tied to 1. rsp_valid appears 1 cycle after each accept, with one request every 2 cycles.
